mem_io_bridge: RTL and testbench
================================

// Module: mem_io_bridge
// PURPOSE
//  Downstream of the cpu top: consumes its byte-wide memory bus (mem_a/mem_dout/mem_wr), returns mem_din.
//  Decodes RAM (mem_a[17:16]!=2'b11) vs I/O (==2'b11) and drives the single-port RAM.
//  Buffers UART output bytes in a TX FIFO, generates io_buffer_full, serves 0x30000/0x30004 reads.
//  Latches program-stop.
// PARAMETERS
//  TX_DEPTH_LOG2   3   TX FIFO depth = 2**TX_DEPTH_LOG2 bytes
//  FULL_MARGIN     2   io_buffer_full=1 when free slots <= FULL_MARGIN (covers cpu's in-flight writes)
//  RAM_ADDR_WIDTH  17  RAM byte-address width (128KB)
// PORTS
//  clk_in          in   1   clock, all state on rising edge
//  rst_in          in   1   synchronous active-high reset
//  rdy_in          in   1   cpu-ready; low = cpu side frozen
//  mem_a           in   32  cpu address (only [17:0] decoded)
//  mem_dout        in   8   cpu write data
//  mem_wr          in   1   1=write, 0=read
//  mem_din         out  8   read data to cpu, valid cycle after request
//  io_buffer_full  out  1   TX FIFO near full
//  ram_a           out  RAM_ADDR_WIDTH  RAM address (=mem_a[16:0])
//  ram_we          out  1   RAM write enable
//  ram_wdata       out  8   RAM write data
//  ram_rdata       in   8   RAM read data, 1-cycle latency
//  tx_data         out  8   UART byte (=FIFO head)
//  tx_valid        out  1   FIFO non-empty
//  tx_ready        in   1   UART accepts byte when tx_valid&tx_ready
//  rx_data         in   8   UART received byte
//  rx_valid        in   1   rx_data holds an unread byte
//  rx_pop          out  1   1-cycle pulse: byte consumed
//  program_stop    out  1   sticky: stop written and TX drained
//  tx_overflow     out  1   sticky: byte dropped on full FIFO
// BEHAVIOUR
//  Reset: all outputs 0 (mem_din, tx_valid, rx_pop, program_stop, tx_overflow, io_buffer_full); FIFO empty, counter 0.
//  rdy_in=0: cpu inputs ignored (no RAM/FIFO push, no rx_pop); mem_din holds; TX drain continues.
//  Request every cycle rdy_in=1; RAM region: ram_we=mem_wr, same cycle (combinational).
//  Read: source select (RAM / rx / counter byte) registered; mem_din valid next cycle from ram_rdata or registered I/O byte.
//  I/O write 0x30000: push mem_dout if !=0x00; data 0x00 ignored. FIFO full and no same-cycle pop -> drop, tx_overflow<=1.
//  Full FIFO with simultaneous pop: push accepted; count unchanged.
//  I/O write 0x30004: stop_pending<=1; program_stop rises first cycle stop_pending & FIFO empty; stays until reset.
//  I/O read 0x30000: mem_din<=rx_valid?rx_data:8'h00; rx_pop=rx_valid, one cycle.
//  I/O read 0x30004..7: mem_din<=cycle_cnt byte mem_a[1:0] (little-endian), snapshot at byte-0 read.
//  Other I/O addresses: reads 0, writes ignored.
//  FIFO: wr/rd pointers width TX_DEPTH_LOG2+1, wrap modulo 2**(TX_DEPTH_LOG2+1); count=wr-rd.
//  io_buffer_full registered: (DEPTH-count_next)<=FULL_MARGIN.
//  cycle_cnt: 32-bit, +1 per cycle rdy_in=1, wraps 0xFFFFFFFF->0.
// CONFIGURATION
//  MEM_IO_CYCLE_COUNTER_EN defined: cycle_cnt, snapshot implemented as above.
//  Undefined: no counter; 0x30004..7 reads return 8'h00.
// STRUCTURE
//  Shared pkg/header: IO_BASE 18'h30000, IO_UART_OFS 2'h0, IO_CLK_OFS 3'h4, read-source enum {SRC_RAM,SRC_IO}.
//  One sub-module: io_tx_fifo (DEPTH, push/pop/full/empty/count).
// TESTING
//  Write 0x41 to 0x30000, tx_ready=1 -> tx_valid next cycle, tx_data=0x41, popped, FIFO empty.
//  tx_ready=0, write 7 bytes (depth 8, margin 2) -> io_buffer_full=1 after 6th push; 9th write -> tx_overflow=1, dropped.
//  Write 0x00 to 0x30000 -> no push, tx_valid stays 0.
//  Write 0x12 to RAM 0x00100, read it back -> ram_we pulse, mem_din=0x12 one cycle after read.
//  Push 3 bytes, write 0x30004, tx_ready=1 -> program_stop rises first cycle after FIFO empties.
//  (EN) 1000 cycles, read 0x30004..7 -> bytes {0xE8,0x03,0x00,0x00} (±snapshot cycle); undef -> all 0.

Source files
------------

// File: rtl/mem_io_bridge_pkg.sv
// Shared definitions for the memory / I/O bridge.
// Holds the I/O map (base address, UART and cycle-counter offsets),
// the read-source selector type and the region decode helper.
package mem_io_bridge_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEC_W     = 18;

  localparam logic [DEC_W-1:0] IO_BASE     = 18'h30000;
  localparam logic [1:0]       IO_UART_OFS = 2'h0;
  localparam logic [2:0]       IO_CLK_OFS  = 3'h4;

  // Selects where mem_din comes from in the cycle after a request.
  typedef enum logic {
    SRC_RAM = 1'b0,
    SRC_IO  = 1'b1
  } rd_src_e;

  // The top quarter of the decoded 256KB window is I/O; the rest is RAM.
  function automatic logic is_io_addr(input logic [DEC_W-1:0] a);
    return a[DEC_W-1:DEC_W-2] == 2'b11;
  endfunction

endpackage

// File: rtl/mem_io_bridge_io_tx_fifo.sv
// UART transmit FIFO.
// Pointers are one bit wider than the index so full and empty are told
// apart without a separate flag; occupancy is wr_ptr - rd_ptr.
// The caller only pushes when there is room (or a pop in the same cycle)
// and only pops when non-empty.
// Ports:
//   clk_in, rst_in  clock, synchronous active-high reset
//   push, push_data write one entry
//   pop             retire the head entry
//   pop_data        head entry
//   empty, full     occupancy flags
//   count           current occupancy
module mem_io_bridge_io_tx_fifo
  import mem_io_bridge_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [DATA_W-1:0]     pop_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (count == PTR_W'(DEPTH));

endmodule

// File: rtl/mem_io_bridge.sv
// Bridge between the cpu byte-wide memory bus and RAM / memory-mapped I/O.
// mem_a[17:16]==2'b11 selects I/O, everything else goes to the RAM.
// I/O map: 0x30000 UART (write = TX byte, read = RX byte),
//          0x30004 write = program stop, 0x30004..7 read = cycle counter.
// Optional feature: define MEM_IO_CYCLE_COUNTER_EN to build the 32-bit
// cycle counter; without it the counter bytes read as 0.
// Ports:
//   clk_in, rst_in, rdy_in          clock, sync active-high reset, cpu ready
//   mem_a, mem_dout, mem_wr, mem_din cpu memory bus
//   ram_a, ram_we, ram_wdata, ram_rdata  single-port RAM (1-cycle read)
//   tx_data, tx_valid, tx_ready     UART transmit stream
//   rx_data, rx_valid, rx_pop       UART receive byte and consume pulse
//   io_buffer_full, program_stop, tx_overflow  status to cpu / host
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int unsigned TX_DEPTH_LOG2  = 3,
  parameter int unsigned FULL_MARGIN    = 2,
  parameter int unsigned RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic [31:0]               mem_a,
  input  logic [7:0]                mem_dout,
  input  logic                      mem_wr,
  output logic [7:0]                mem_din,
  output logic                      io_buffer_full,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a,
  output logic                      ram_we,
  output logic [7:0]                ram_wdata,
  input  logic [7:0]                ram_rdata,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_pop,
  output logic                      program_stop,
  output logic                      tx_overflow
);

  localparam int unsigned CNT_W = TX_DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << TX_DEPTH_LOG2;
  localparam logic [DEC_W-1:0] IO_UART_ADDR = IO_BASE | DEC_W'(IO_UART_OFS);
  localparam logic [DEC_W-1:0] IO_CLK_ADDR  = IO_BASE | DEC_W'(IO_CLK_OFS);

  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_a[31:DEC_W];

  // Address decode.
  logic is_io, uart_hit, clk_hit, stop_hit, io_wr, io_rd;
  assign is_io    = is_io_addr(mem_a[DEC_W-1:0]);
  assign uart_hit = (mem_a[DEC_W-1:0] == IO_UART_ADDR);
  assign clk_hit  = (mem_a[DEC_W-1:2] == IO_CLK_ADDR[DEC_W-1:2]);
  assign stop_hit = (mem_a[DEC_W-1:0] == IO_CLK_ADDR);
  assign io_wr    = rdy_in && is_io && mem_wr;
  assign io_rd    = rdy_in && is_io && !mem_wr;

  // RAM is driven combinationally in the request cycle.
  assign ram_a     = mem_a[RAM_ADDR_WIDTH-1:0];
  assign ram_wdata = mem_dout;
  assign ram_we    = rdy_in && !is_io && mem_wr;

  // TX FIFO: a full FIFO still takes a byte when the head leaves the same cycle.
  logic             fifo_empty, fifo_full, tx_pop, push_req, push_ok;
  logic [CNT_W-1:0] fifo_count, fifo_count_next;

  assign tx_valid = !fifo_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign push_req = io_wr && uart_hit && (mem_dout != 8'h00);
  assign push_ok  = push_req && (!fifo_full || tx_pop);
  assign fifo_count_next = fifo_count + CNT_W'(push_ok) - CNT_W'(tx_pop);

  mem_io_bridge_io_tx_fifo #(
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_io_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (push_ok),
    .push_data (mem_dout),
    .pop       (tx_pop),
    .pop_data  (tx_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Cycle counter byte for 0x30004..7; upper bytes come from the snapshot
  // taken on the byte-0 read so a multi-byte read is coherent.
  logic [7:0] clk_byte;
`ifdef MEM_IO_CYCLE_COUNTER_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [23:0] snap_q, snap_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    snap_d    = snap_q;
    clk_byte  = cyc_cnt_q[7:0];
    if (rdy_in) cyc_cnt_d = cyc_cnt_q + 32'd1;
    if (io_rd && clk_hit && (mem_a[1:0] == 2'd0)) snap_d = cyc_cnt_q[31:8];
    case (mem_a[1:0])
      2'd1:    clk_byte = snap_q[7:0];
      2'd2:    clk_byte = snap_q[15:8];
      2'd3:    clk_byte = snap_q[23:16];
      default: clk_byte = cyc_cnt_q[7:0];
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cyc_cnt_q <= '0;
      snap_q    <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      snap_q    <= snap_d;
    end
  end
`else
  assign clk_byte = 8'h00;
`endif

  // Read return and status state.
  rd_src_e    src_q, src_d;
  logic [7:0] io_byte_q, io_byte_d;
  logic [7:0] hold_q, hold_d;
  logic       req_q, req_d;
  logic       rx_pop_q, rx_pop_d;
  logic       overflow_q, overflow_d;
  logic       stop_pending_q, stop_pending_d;
  logic       program_stop_q, program_stop_d;
  logic       buf_full_q, buf_full_d;

  // RAM data arrives the cycle after the request, so mem_din is a mux;
  // while the cpu is frozen it replays the last returned byte.
  assign mem_din = !req_q           ? hold_q :
                   (src_q == SRC_RAM) ? ram_rdata : io_byte_q;

  always_comb begin
    src_d          = src_q;
    io_byte_d      = io_byte_q;
    hold_d         = mem_din;
    req_d          = rdy_in;
    rx_pop_d       = 1'b0;
    overflow_d     = overflow_q || (push_req && fifo_full && !tx_pop);
    stop_pending_d = stop_pending_q || (io_wr && stop_hit);
    program_stop_d = program_stop_q || (stop_pending_q && fifo_empty);
    buf_full_d     = (32'(DEPTH) - 32'(fifo_count_next)) <= 32'(FULL_MARGIN);
    if (rdy_in) begin
      src_d     = is_io ? SRC_IO : SRC_RAM;
      io_byte_d = 8'h00;
      if (io_rd && uart_hit) begin
        io_byte_d = rx_valid ? rx_data : 8'h00;
        rx_pop_d  = rx_valid;
      end else if (io_rd && clk_hit) begin
        io_byte_d = clk_byte;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_q          <= SRC_IO;
      io_byte_q      <= '0;
      hold_q         <= '0;
      req_q          <= 1'b0;
      rx_pop_q       <= 1'b0;
      overflow_q     <= 1'b0;
      stop_pending_q <= 1'b0;
      program_stop_q <= 1'b0;
      buf_full_q     <= 1'b0;
    end else begin
      src_q          <= src_d;
      io_byte_q      <= io_byte_d;
      hold_q         <= hold_d;
      req_q          <= req_d;
      rx_pop_q       <= rx_pop_d;
      overflow_q     <= overflow_d;
      stop_pending_q <= stop_pending_d;
      program_stop_q <= program_stop_d;
      buf_full_q     <= buf_full_d;
    end
  end

  assign rx_pop         = rx_pop_q;
  assign tx_overflow    = overflow_q;
  assign program_stop   = program_stop_q;
  assign io_buffer_full = buf_full_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge with a 1-cycle-latency RAM model.
module tb_mem_io_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_pop;
  logic        program_stop, tx_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  mem_io_bridge dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .ram_a          (ram_a),
    .ram_we         (ram_we),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_pop         (rx_pop),
    .program_stop   (program_stop),
    .tx_overflow    (tx_overflow)
  );

  // Single-port RAM, read-before-write, one cycle read latency.
  logic [7:0] ram [0:131071];
  always @(posedge clk_in) begin
    if (ram_we) ram[ram_a] <= ram_wdata;
    ram_rdata <= ram[ram_a];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    mem_a    = 32'h0;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
  endtask

  task automatic reset_dut();
    rst_in   = 1'b1;
    rdy_in   = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle();
    repeat (3) tick();
    rst_in = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    mem_a    = a;
    mem_dout = d;
    mem_wr   = 1'b1;
    tick();
    idle();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [7:0] d);
    mem_a  = a;
    mem_wr = 1'b0;
    tick();
    d = mem_din;
    idle();
  endtask

  logic [7:0] rd;
  logic [7:0] exp_b;
  int         n;

  initial begin
    // Reset state, sampled while reset is still asserted.
    rst_in   = 1'b1;
    rdy_in   = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle();
    repeat (3) tick();
    check("rst_mem_din", mem_din, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_rx_pop", rx_pop, 0);
    check("rst_program_stop", program_stop, 0);
    check("rst_tx_overflow", tx_overflow, 0);
    check("rst_io_buffer_full", io_buffer_full, 0);
    rst_in = 1'b0;

    // Single byte through the TX FIFO.
    tx_ready = 1'b1;
    bus_write(32'h30000, 8'h41);
    check("tx1_valid", tx_valid, 1);
    check("tx1_data", tx_data, 8'h41);
    tick();
    check("tx1_drained", tx_valid, 0);
    check("tx1_no_overflow", tx_overflow, 0);

    // Zero byte is not pushed.
    tx_ready = 1'b0;
    bus_write(32'h30000, 8'h00);
    check("zero_no_push", tx_valid, 0);

    // Fill to overflow, then a push that coincides with a pop.
    reset_dut();
    for (int k = 1; k <= 9; k++) begin
      bus_write(32'h30000, 8'(k));
      if (k == 5) check("full_after5", io_buffer_full, 0);
      if (k == 6) check("full_after6", io_buffer_full, 1);
      if (k == 8) check("ovf_after8", tx_overflow, 0);
      if (k == 9) check("ovf_after9", tx_overflow, 1);
    end
    tx_ready = 1'b1;
    bus_write(32'h30000, 8'h99);
    for (int i = 0; i < 8; i++) begin
      exp_b = (i < 7) ? 8'(i + 2) : 8'h99;
      check("drain_valid", tx_valid, 1);
      check("drain_data", tx_data, exp_b);
      tick();
    end
    check("drain_empty", tx_valid, 0);

    // RAM write / read-back and cpu freeze.
    reset_dut();
    mem_a = 32'h00100; mem_dout = 8'h12; mem_wr = 1'b1;
    #1 check("ram_we_high", ram_we, 1);
    tick();
    mem_a = 32'h00200; mem_dout = 8'h34; mem_wr = 1'b1;
    tick();
    mem_a = 32'h00100; mem_wr = 1'b0;
    #1 check("ram_we_low", ram_we, 0);
    tick();
    check("ram_readback", mem_din, 8'h12);
    rdy_in = 1'b0;
    mem_a  = 32'h00200;
    tick();
    check("frozen_hold", mem_din, 8'h12);
    mem_wr = 1'b1; mem_dout = 8'h77;
    #1 check("frozen_ram_we", ram_we, 0);
    mem_a = 32'h30000; mem_dout = 8'h55;
    tick();
    check("frozen_no_push", tx_valid, 0);
    rdy_in = 1'b1;
    idle();

    // UART receive path and unmapped I/O.
    rx_valid = 1'b1; rx_data = 8'h5A;
    bus_read(32'h30000, rd);
    check("rx_data", rd, 8'h5A);
    check("rx_pop_pulse", rx_pop, 1);
    rx_valid = 1'b0;
    tick();
    check("rx_pop_clear", rx_pop, 0);
    bus_read(32'h30000, rd);
    check("rx_empty_data", rd, 8'h00);
    check("rx_empty_pop", rx_pop, 0);
    bus_write(32'h30010, 8'hAB);
    bus_read(32'h30010, rd);
    check("unmapped_read", rd, 8'h00);
    check("unmapped_no_push", tx_valid, 0);

    // Program stop waits for the FIFO to drain.
    reset_dut();
    bus_write(32'h30000, 8'h10);
    bus_write(32'h30000, 8'h11);
    bus_write(32'h30000, 8'h12);
    bus_write(32'h30004, 8'h01);
    check("stop_early", program_stop, 0);
    tx_ready = 1'b1;
    n = 0;
    while (tx_valid && n < 20) begin
      tick();
      n++;
    end
    check("stop_drain_timeout", tx_valid, 0);
    check("stop_at_empty", program_stop, 0);
    tick();
    check("stop_rise", program_stop, 1);
    repeat (3) tick();
    check("stop_sticky", program_stop, 1);

    // Cycle counter: 1000 ready cycles since reset release.
    reset_dut();
    repeat (1000) tick();
    for (int b = 0; b < 4; b++) begin
      bus_read(32'h30004 + 32'(b), rd);
`ifdef MEM_IO_CYCLE_COUNTER_EN
      case (b)
        0:       exp_b = 8'hE8;
        1:       exp_b = 8'h03;
        default: exp_b = 8'h00;
      endcase
`else
      exp_b = 8'h00;
`endif
      check("clk_byte", rd, exp_b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
